// File: rtl/lfsr_checker.sv
// lfsr_checker: synchronises to an incoming LFSR word stream, then flywheels a
// local copy of the same LFSR and compares every valid word against it.
// Reports lock status, per-word error pulses, a saturating error count and
// the measured sequence period.
module lfsr_checker #(
  parameter int                    LFSR_WIDTH    = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = 8'hB8,
  parameter int                    LOCK_COUNT    = 4,
  parameter int                    UNLOCK_ERRORS = 4,
  parameter int                    CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_soft_reset,
  input  logic                  i_valid,
  input  logic [LFSR_WIDTH-1:0] i_LFSR,
  output logic                  o_lock,
  output logic                  o_error,
  output logic [CNT_WIDTH-1:0]  o_err_count,
  output logic [CNT_WIDTH-1:0]  o_period,
  output logic                  o_period_valid,
  output logic                  o_zero
);

  localparam int MW = (LOCK_COUNT    < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int UW = (UNLOCK_ERRORS < 2) ? 1 : $clog2(UNLOCK_ERRORS + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  // Fibonacci-style step: shift left, feedback parity of the tapped bits into bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
    return {cur[LFSR_WIDTH-2:0], ^(cur & TAPS)};
  endfunction

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] expected_q, expected_d;
  logic [LFSR_WIDTH-1:0] ref_q, ref_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d;
  logic [UW-1:0]         err_run_q, err_run_d;
  logic [CNT_WIDTH-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic                  lock_q, lock_d;
  logic                  error_q, error_d;
  logic                  period_valid_q, period_valid_d;
  logic                  zero_q, zero_d;

  logic [MW-1:0]         match_inc;
  logic [UW-1:0]         err_run_inc;

  assign match_inc   = match_cnt_q + 1'b1;
  assign err_run_inc = err_run_q + 1'b1;

  // Next-state and output computation for one sampled word.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    expected_d     = expected_q;
    ref_d          = ref_q;
    match_cnt_d    = match_cnt_q;
    err_run_d      = err_run_q;
    period_cnt_d   = period_cnt_q;
    err_count_d    = err_count_q;
    period_d       = period_q;
    error_d        = 1'b0;
    period_valid_d = 1'b0;
    zero_d         = 1'b0;

    if (i_soft_reset) begin
      // Word sampled alongside a soft reset is discarded; measured period survives.
      state_d      = S_SEARCH;
      match_cnt_d  = '0;
      err_run_d    = '0;
      period_cnt_d = '0;
      err_count_d  = '0;
    end else if (i_valid) begin
      unique case (state_q)
        S_SEARCH: begin
          if (i_LFSR == '0) begin
            zero_d = 1'b1;
          end else begin
            expected_d  = lfsr_next(i_LFSR);
            match_cnt_d = '0;
            state_d     = S_VERIFY;
          end
        end

        S_VERIFY: begin
          if (i_LFSR == expected_q) begin
            match_cnt_d = match_inc;
            expected_d  = lfsr_next(i_LFSR);
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d      = S_LOCKED;
              ref_d        = i_LFSR;
              period_cnt_d = '0;
              err_run_d    = '0;
            end
          end else if (i_LFSR != '0) begin
            // Re-seed from the new word and start counting matches again.
            expected_d  = lfsr_next(i_LFSR);
            match_cnt_d = '0;
          end else begin
            zero_d  = 1'b1;
            state_d = S_SEARCH;
          end
        end

        S_LOCKED: begin
          // Flywheel: the local LFSR advances on its own, never from data.
          expected_d = lfsr_next(expected_q);

          if (i_LFSR == ref_q) begin
            period_d       = period_cnt_q + 1'b1;
            period_valid_d = 1'b1;
            period_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + 1'b1;
          end

          if (i_LFSR != expected_q) begin
            error_d   = 1'b1;
            err_run_d = err_run_inc;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (err_run_inc == UW'(UNLOCK_ERRORS)) begin
              state_d      = S_SEARCH;
              period_cnt_d = '0;
            end
          end else begin
            err_run_d = '0;
          end
        end

        default: state_d = S_SEARCH;
      endcase
    end

    lock_d = (state_d == S_LOCKED);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (i_reset) begin
      state_q        <= S_SEARCH;
      expected_q     <= '0;
      ref_q          <= '0;
      match_cnt_q    <= '0;
      err_run_q      <= '0;
      period_cnt_q   <= '0;
      err_count_q    <= '0;
      period_q       <= '0;
      lock_q         <= 1'b0;
      error_q        <= 1'b0;
      period_valid_q <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      ref_q          <= ref_d;
      match_cnt_q    <= match_cnt_d;
      err_run_q      <= err_run_d;
      period_cnt_q   <= period_cnt_d;
      err_count_q    <= err_count_d;
      period_q       <= period_d;
      lock_q         <= lock_d;
      error_q        <= error_d;
      period_valid_q <= period_valid_d;
      zero_q         <= zero_d;
    end
  end

  assign o_lock         = lock_q;
  assign o_error        = error_q;
  assign o_err_count    = err_count_q;
  assign o_period       = period_q;
  assign o_period_valid = period_valid_q;
  assign o_zero         = zero_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scenarios for lfsr_checker with default parameters
// (8-bit, taps 8'hB8, lock after 4 matches, unlock after 4 errors).
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_soft_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_LFSR = 8'h00;
  logic        o_lock;
  logic        o_error;
  logic [31:0] o_err_count;
  logic [31:0] o_period;
  logic        o_period_valid;
  logic        o_zero;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] cur;

  lfsr_checker dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_soft_reset   (i_soft_reset),
    .i_valid        (i_valid),
    .i_LFSR         (i_LFSR),
    .o_lock         (o_lock),
    .o_error        (o_error),
    .o_err_count    (o_err_count),
    .o_period       (o_period),
    .o_period_valid (o_period_valid),
    .o_zero         (o_zero)
  );

  always #5 clk = ~clk;

  // Generator model used only to produce stimulus words.
  function automatic logic [7:0] nxt(input logic [7:0] c);
    return {c[6:0], ^(c & 8'hB8)};
  endfunction

  // Apply one cycle of inputs, sample outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] w, input logic sr, input logic r);
    i_valid      = v;
    i_LFSR       = w;
    i_soft_reset = sr;
    i_reset      = r;
    @(posedge clk);
    #1;
    i_valid      = 1'b0;
    i_soft_reset = 1'b0;
    i_reset      = 1'b0;
  endtask

  task automatic send_clean();
    step(1'b1, cur, 1'b0, 1'b0);
    cur = nxt(cur);
  endtask

  task automatic send_flip();
    step(1'b1, cur ^ 8'h10, 1'b0, 1'b0);
    cur = nxt(cur);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic lock_up(input logic [7:0] seed);
    do_reset();
    cur = seed;
    repeat (5) send_clean();
    n_checks++;
    if (o_lock !== 1'b1) $display("FAIL lock_up: o_lock=%0b expected 1", o_lock);
    else n_pass++;
  endtask

  task automatic test_reset();
    // Reset concurrent with a valid word: the word is discarded.
    step(1'b1, 8'h55, 1'b0, 1'b1);
    n_checks++;
    if ({o_lock, o_error, o_period_valid, o_zero} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {o_lock, o_error, o_period_valid, o_zero});
    else n_pass++;
    n_checks++;
    if (o_err_count !== 32'd0) $display("FAIL reset_err_count: got %0d expected 0", o_err_count);
    else n_pass++;
    n_checks++;
    if (o_period !== 32'd0) $display("FAIL reset_period: got %0d expected 0", o_period);
    else n_pass++;
  endtask

  task automatic test_clean();
    int lock_idx = 0;
    int pv1 = 0;
    int pv2 = 0;
    int errs = 0;
    do_reset();
    cur = 8'h01;
    for (int k = 1; k <= 520; k++) begin
      send_clean();
      if (o_lock === 1'b1 && lock_idx == 0) lock_idx = k;
      if (o_period_valid === 1'b1) begin
        if (pv1 == 0) pv1 = k;
        else if (pv2 == 0) pv2 = k;
      end
      if (o_error !== 1'b0) errs++;
    end
    n_checks++;
    if (lock_idx != 5) $display("FAIL clean_lock_idx: got %0d expected 5", lock_idx);
    else n_pass++;
    n_checks++;
    if (pv1 != 260) $display("FAIL clean_first_period_pulse: got word %0d expected 260", pv1);
    else n_pass++;
    n_checks++;
    if (pv2 != 515) $display("FAIL clean_second_period_pulse: got word %0d expected 515", pv2);
    else n_pass++;
    n_checks++;
    if (o_period !== 32'd255) $display("FAIL clean_period: got %0d expected 255", o_period);
    else n_pass++;
    n_checks++;
    if (o_err_count !== 32'd0 || errs != 0)
      $display("FAIL clean_errors: count=%0d pulses=%0d expected 0/0", o_err_count, errs);
    else n_pass++;
    n_checks++;
    if (o_lock !== 1'b1) $display("FAIL clean_lock_held: got %0b expected 1", o_lock);
    else n_pass++;
  endtask

  // Continues from the locked state left by test_clean.
  task automatic test_bit_flip();
    int errs = 0;
    send_flip();
    n_checks++;
    if ({o_error, o_lock} !== 2'b11) $display("FAIL flip_pulse_lock: got %b expected 11", {o_error, o_lock});
    else n_pass++;
    n_checks++;
    if (o_err_count !== 32'd1) $display("FAIL flip_count: got %0d expected 1", o_err_count);
    else n_pass++;
    repeat (8) begin
      send_clean();
      if (o_error !== 1'b0) errs++;
    end
    n_checks++;
    if (errs != 0 || o_err_count !== 32'd1 || o_lock !== 1'b1)
      $display("FAIL flip_after: pulses=%0d count=%0d lock=%0b expected 0/1/1", errs, o_err_count, o_lock);
    else n_pass++;
  endtask

  task automatic test_burst();
    lock_up(8'h01);
    for (int i = 1; i <= 4; i++) begin
      send_flip();
      n_checks++;
      if (o_error !== 1'b1 || o_lock !== (i < 4))
        $display("FAIL burst_word%0d: error=%0b lock=%0b expected 1/%0b", i, o_error, o_lock, (i < 4));
      else n_pass++;
    end
    n_checks++;
    if (o_err_count !== 32'd4) $display("FAIL burst_count: got %0d expected 4", o_err_count);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      send_clean();
      n_checks++;
      if (o_lock !== (k == 5)) $display("FAIL burst_relock_word%0d: got %0b expected %0b", k, o_lock, (k == 5));
      else n_pass++;
    end
    n_checks++;
    if (o_err_count !== 32'd4) $display("FAIL burst_count_after_relock: got %0d expected 4", o_err_count);
    else n_pass++;
  endtask

  task automatic test_zero();
    int bad = 0;
    do_reset();
    repeat (6) begin
      step(1'b1, 8'h00, 1'b0, 1'b0);
      if (o_zero !== 1'b1 || o_lock !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL zero_stream: %0d words without zero pulse or with lock, expected 0", bad);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (o_zero !== 1'b0) $display("FAIL zero_idle: got %0b expected 0", o_zero);
    else n_pass++;
    // Zero while verifying falls back to SEARCH: five more clean words needed.
    cur = 8'h37;
    send_clean();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (o_zero !== 1'b1) $display("FAIL zero_in_verify: got %0b expected 1", o_zero);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      send_clean();
      n_checks++;
      if (o_lock !== (k == 5)) $display("FAIL zero_relock_word%0d: got %0b expected %0b", k, o_lock, (k == 5));
      else n_pass++;
    end
  endtask

  task automatic test_gapped();
    int vcount = 0;
    int cycles = 0;
    int lock_idx = 0;
    int pv1 = 0;
    int pv2 = 0;
    int gap_pulses = 0;
    do_reset();
    cur = 8'h01;
    while (vcount < 520 && cycles < 3000) begin
      cycles++;
      if ($urandom_range(0, 2) != 0) begin
        send_clean();
        vcount++;
        if (o_lock === 1'b1 && lock_idx == 0) lock_idx = vcount;
        if (o_period_valid === 1'b1) begin
          if (pv1 == 0) pv1 = vcount;
          else if (pv2 == 0) pv2 = vcount;
        end
      end else begin
        step(1'b0, 8'($urandom), 1'b0, 1'b0);
        if ({o_error, o_period_valid, o_zero} !== 3'b000) gap_pulses++;
      end
    end
    n_checks++;
    if (vcount != 520) $display("FAIL gapped_budget: got %0d words expected 520", vcount);
    else n_pass++;
    n_checks++;
    if (lock_idx != 5) $display("FAIL gapped_lock_idx: got %0d expected 5", lock_idx);
    else n_pass++;
    n_checks++;
    if (pv1 != 260 || pv2 != 515) $display("FAIL gapped_period_pulses: got %0d,%0d expected 260,515", pv1, pv2);
    else n_pass++;
    n_checks++;
    if (o_period !== 32'd255 || gap_pulses != 0)
      $display("FAIL gapped_period: period=%0d gap_pulses=%0d expected 255/0", o_period, gap_pulses);
    else n_pass++;
  endtask

  // Reach o_err_count=3 while locked, then hit it with soft or hard reset.
  task automatic reset_while_locked(input logic hard);
    send_flip(); send_clean();
    send_flip(); send_clean();
    send_flip();
    n_checks++;
    if (o_err_count !== 32'd3 || o_lock !== 1'b1)
      $display("FAIL rst%0b_precond: count=%0d lock=%0b expected 3/1", hard, o_err_count, o_lock);
    else n_pass++;
    step(1'b1, cur, !hard, hard);
    cur = nxt(cur);
    n_checks++;
    if ({o_lock, o_error, o_period_valid, o_zero} !== 4'b0000 || o_err_count !== 32'd0)
      $display("FAIL rst%0b_clear: flags=%b count=%0d expected 0000/0", hard,
               {o_lock, o_error, o_period_valid, o_zero}, o_err_count);
    else n_pass++;
    n_checks++;
    if (o_period !== (hard ? 32'd0 : 32'd255))
      $display("FAIL rst%0b_period: got %0d expected %0d", hard, o_period, (hard ? 0 : 255));
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      send_clean();
      n_checks++;
      if (o_lock !== (k == 5)) $display("FAIL rst%0b_relock_word%0d: got %0b expected %0b", hard, k, o_lock, (k == 5));
      else n_pass++;
    end
  endtask

  task automatic test_soft_reset();
    lock_up(8'h01);
    repeat (255) send_clean();
    n_checks++;
    if (o_period !== 32'd255) $display("FAIL soft_setup_period: got %0d expected 255", o_period);
    else n_pass++;
    reset_while_locked(1'b0);
    reset_while_locked(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_clean();
    test_bit_flip();
    test_burst();
    test_zero();
    test_gapped();
    test_soft_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
